// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller: FSM state encoding
// and the default word written by the hardware clear sequence.
package spram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2,
        INIT    = 2'd3
    } ctrl_state_e;

    localparam int unsigned INIT_VALUE_DEFAULT = 0;

endpackage

// File: rtl/single_port_RAM.sv
// Single-port RAM with synchronous write and one-cycle registered read,
// driven by spram_controller.
module single_port_RAM #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[addr] <= d_in;
        end
        if (rd) begin
            d_out <= mem_q[addr];
        end
    end

endmodule

// File: rtl/spram_controller.sv
// Valid/ready request/response front end for a single-port RAM with a
// hardware clear sequence that fills every address with INIT_VALUE.
module spram_controller
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  init_start,
    output logic                  busy,
    output logic                  init_done,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    ctrl_state_e           state_q, state_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  init_done_q, init_done_d;
    // Next address the clear sequence will write; wraps to 0 after the last one.
    logic [ADDR_WIDTH-1:0] clr_next_q, clr_next_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            init_done_q <= 1'b0;
            clr_next_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            init_done_q <= init_done_d;
            clr_next_q  <= clr_next_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        init_done_d = 1'b0;
        clr_next_d  = clr_next_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = !init_start;
                if (init_start) begin
                    // The first clear write is issued on the entry edge so the
                    // sequence occupies exactly one cycle per address.
                    state_d    = INIT;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = '0;
                    mem_din_d  = INIT_VALUE;
                    clr_next_d = ADDR_WIDTH'(1);
                end else if (req_valid) begin
                    mem_addr_d = req_addr;
                    if (req_we) begin
                        mem_wr_d  = 1'b1;
                        mem_din_d = req_wdata;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Stay while the read strobe is still out, then one more cycle
                // so the response appears two edges after acceptance.
                if (!mem_rd_q) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                if (clr_next_q == '0) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = clr_next_q;
                    mem_din_d  = INIT_VALUE;
                    clr_next_d = clr_next_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign init_done = init_done_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign rsp_data  = mem_dout;

endmodule

// File: tb/tb_spram_controller.sv
// Self-checking bench for spram_controller attached to single_port_RAM:
// table vectors, corner-case sequences and random traffic against a memory model.
module tb_spram_controller;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [DW-1:0] INITV = 8'h3C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_start, busy, init_done;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] model [DEPTH];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            hold;
        logic [DW-1:0] expData;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    spram_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INITV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_start(init_start), .busy(busy), .init_done(init_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    single_port_RAM #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram (
        .clk(clk), .rd(mem_rd), .wr(mem_wr), .addr(mem_addr),
        .d_in(mem_din), .d_out(mem_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReady(input string name);
        int waitCnt;
        waitCnt = 0;
        while (!req_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput({name, " req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string name);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        #1;
        waitReady(name);
        tick();
        req_valid = 1'b0;
        checkOutput({name, " mem_wr"}, 32'(mem_wr), 32'd1);
        checkOutput({name, " mem_addr"}, 32'(mem_addr), 32'(addr));
        checkOutput({name, " mem_din"}, 32'(mem_din), 32'(data));
        model[addr] = data;
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input int hold, input logic [DW-1:0] exp, input string name);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        #1;
        waitReady(name);
        tick();
        req_valid = 1'b0;
        checkOutput({name, " mem_rd"}, 32'({mem_rd, mem_wr}), 32'd2);
        checkOutput({name, " rd addr"}, 32'(mem_addr), 32'(addr));
        tick();
        checkOutput({name, " early rsp_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            checkOutput({name, " hold rsp"}, 32'({rsp_valid, rsp_data}), 32'({1'b1, exp}));
            checkOutput({name, " hold req_ready"}, 32'(req_ready), 32'd0);
            checkOutput({name, " hold strobes"}, 32'({mem_rd, mem_wr}), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput({name, " rsp_data"}, 32'(rsp_data), 32'(exp));
        tick();
        rsp_ready = 1'b0;
        checkOutput({name, " rsp done"}, 32'({rsp_valid, busy}), 32'd0);
    endtask

    // Runs a full clear; optionally with a competing write and a stray init_start mid-sequence.
    task automatic applyStimulus(input logic withWrite);
        if (withWrite) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 4'h7;
            req_wdata = 8'hEE;
        end
        init_start = 1'b1;
        #1;
        checkOutput("init req_ready", 32'(req_ready), 32'd0);
        tick();
        init_start = 1'b0;
        req_valid  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (withWrite && i == 5) init_start = 1'b1;
            if (withWrite && i == 6) init_start = 1'b0;
            checkOutput("init busy", 32'(busy), 32'd1);
            checkOutput("init mem_wr", 32'({mem_rd, mem_wr}), 32'd1);
            checkOutput("init mem_addr", 32'(mem_addr), 32'(i));
            checkOutput("init mem_din", 32'(mem_din), 32'(INITV));
            checkOutput("init no early done", 32'(init_done), 32'd0);
            tick();
        end
        checkOutput("init end busy", 32'(busy), 32'd0);
        checkOutput("init_done pulse", 32'(init_done), 32'd1);
        checkOutput("init end mem_wr", 32'(mem_wr), 32'd0);
        tick();
        checkOutput("init_done single", 32'(init_done), 32'd0);
        for (int a = 0; a < int'(DEPTH); a++) model[a] = INITV;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        init_start = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;

        vecs[0] = '{1'b1, 4'hA, 8'hA5, 0, 8'h00};
        vecs[1] = '{1'b0, 4'hA, 8'h00, 0, 8'hA5};
        vecs[2] = '{1'b1, 4'hF, 8'h5A, 0, 8'h00};
        vecs[3] = '{1'b0, 4'hF, 8'h00, 2, 8'h5A};
        vecs[4] = '{1'b1, 4'h0, 8'hC3, 0, 8'h00};
        vecs[5] = '{1'b0, 4'h0, 8'h00, 0, 8'hC3};
        vecs[6] = '{1'b0, 4'h5, 8'h00, 0, 8'h3C};
        vecs[7] = '{1'b1, 4'hA, 8'h11, 0, 8'h00};
        vecs[8] = '{1'b0, 4'hA, 8'h00, 5, 8'h11};
        vecs[9] = '{1'b0, 4'hF, 8'h00, 1, 8'h5A};

        #3;
        checkOutput("reset strobes", 32'({mem_rd, mem_wr}), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset mem_din", 32'(mem_din), 32'd0);
        checkOutput("reset status", 32'({rsp_valid, init_done, busy}), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        applyStimulus(1'b0);
        doRead(4'hF, 0, 8'h3C, "clear readback");

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].we) doWrite(vecs[v].addr, vecs[v].wdata, $sformatf("vec%0d wr", v));
            else            doRead(vecs[v].addr, vecs[v].hold, vecs[v].expData, $sformatf("vec%0d rd", v));
        end

        req_valid = 1'b1;
        req_we    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr  = 4'(i);
            req_wdata = 8'(8'h80 + i);
            #1;
            checkOutput("b2b req_ready", 32'(req_ready), 32'd1);
            tick();
            checkOutput("b2b mem_wr", 32'({mem_wr, mem_addr}), 32'({1'b1, 4'(i)}));
            model[i] = 8'(8'h80 + i);
        end
        req_valid = 1'b0;
        tick();
        checkOutput("b2b mem_wr off", 32'(mem_wr), 32'd0);
        doRead(4'h0, 0, 8'h80, "b2b rd0");
        doRead(4'h3, 0, 8'h83, "b2b rd3");

        applyStimulus(1'b1);
        doRead(4'h7, 0, 8'h3C, "blocked write");

        for (int a = 0; a < int'(DEPTH); a++) doWrite(4'(a), 8'(a * 7 + 1), "prefill");
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (4) tick();
        checkOutput("5th init cycle addr", 32'({mem_wr, mem_addr}), 32'({1'b1, 4'h4}));
        rst_n = 1'b0;
        #1;
        checkOutput("async reset strobes", 32'({mem_rd, mem_wr}), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) model[a] = INITV;
        for (int a = 0; a < int'(DEPTH); a++) doRead(4'(a), 0, model[a], "abort readback");

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] ra;
            ra = 4'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) doWrite(ra, 8'($urandom), "rnd wr");
            else                           doRead(ra, int'($urandom_range(0, 3)), model[ra], "rnd rd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
